// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;

   // A fetch is legal when it is word aligned and the whole word fits in memory.
   function automatic logic is_legal_fetch(input logic [31:0] addr,
                                           input logic [31:0] imem_bytes);
      return (addr[1:0] == 2'b00) && (addr <= imem_bytes - 32'(INSTR_BYTES));
   endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Performance counters for the fetch unit: accepted handshakes and decode
// back-pressure cycles. Both counters wrap and hold while frozen.
module fetch_perf_counters
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        accept,
   input  logic        stall_cycle,
   input  logic        freeze,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   // Count events unless frozen; synchronous clear on reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else if (!freeze) begin
         if (accept)      fetch_cnt <= fetch_cnt + 32'd1;
         if (stall_cycle) stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the synchronous ROM address,
// pairs each returned word with its PC and hands it to decode.
// Handshake: a word transfers on a cycle where out_valid && out_ready; once
// out_valid is high, out_instr/out_pc hold until accepted or a redirect.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 128
)
(
   input  logic         clk,
   input  logic         resetn,
   output logic [31:0]  imem_addr,
   input  logic [31:0]  imem_rdata,
   output logic [31:0]  out_instr,
   output logic [31:0]  out_pc,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_target,
   output logic         fetch_fault,
   output logic [31:0]  fault_addr,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]  perf_fetch_cnt,
   output logic [31:0]  perf_stall_cnt,
`endif
   output fetch_state_e state
);

   localparam logic [31:0] MEM_BYTES = 32'(IMEM_BYTES);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  inflight_pc_q, inflight_pc_d;
   logic         inflight_valid_q, inflight_valid_d;
   logic         fault_q, fault_d;
   logic [31:0]  fault_addr_q, fault_addr_d;
   logic         stall;
   logic         in_fault;

   assign in_fault    = (state_q == FAULT);
   assign stall       = inflight_valid_q && !out_ready && !redirect_valid;
   assign out_valid   = resetn && inflight_valid_q && !in_fault && !redirect_valid;
   assign out_instr   = out_valid ? imem_rdata : 32'd0;
   assign out_pc      = resetn ? inflight_pc_q : 32'd0;
   assign fetch_fault = fault_q;
   assign fault_addr  = fault_addr_q;
   assign state       = state_q;

   // Address mux: redirect beats stall replay beats sequential fetch; frozen in FAULT.
   always_comb begin
      imem_addr = fetch_pc_q;
      if (!resetn) begin
         imem_addr = PC_RESET;
      end else if (!in_fault) begin
         if (redirect_valid) imem_addr = redirect_target;
         else if (stall)     imem_addr = inflight_pc_q;
      end
   end

   // Next-state logic for the PC pipeline and the BOOT/RUN/FAULT controller.
   always_comb begin
      state_d          = state_q;
      fetch_pc_d       = fetch_pc_q;
      inflight_pc_d    = inflight_pc_q;
      inflight_valid_d = inflight_valid_q;
      fault_d          = fault_q;
      fault_addr_d     = fault_addr_q;
      if (!in_fault) begin
         if (redirect_valid) begin
            if (is_legal_fetch(redirect_target, MEM_BYTES)) begin
               inflight_pc_d    = redirect_target;
               inflight_valid_d = 1'b1;
               fetch_pc_d       = redirect_target + 32'd4;
               state_d          = RUN;
            end else begin
               state_d          = FAULT;
               fault_addr_d     = redirect_target;
               fault_d          = 1'b1;
               inflight_valid_d = 1'b0;
            end
         end else if (!stall) begin
            if (is_legal_fetch(fetch_pc_q, MEM_BYTES)) begin
               inflight_pc_d    = fetch_pc_q;
               inflight_valid_d = 1'b1;
               fetch_pc_d       = fetch_pc_q + 32'd4;
               state_d          = RUN;
            end else begin
               state_d          = FAULT;
               fault_addr_d     = fetch_pc_q;
               fault_d          = 1'b1;
               inflight_valid_d = 1'b0;
            end
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q          <= BOOT;
         fetch_pc_q       <= PC_RESET;
         inflight_pc_q    <= 32'd0;
         inflight_valid_q <= 1'b0;
         fault_q          <= 1'b0;
         fault_addr_q     <= 32'd0;
      end else begin
         state_q          <= state_d;
         fetch_pc_q       <= fetch_pc_d;
         inflight_pc_q    <= inflight_pc_d;
         inflight_valid_q <= inflight_valid_d;
         fault_q          <= fault_d;
         fault_addr_q     <= fault_addr_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   fetch_perf_counters u_perf (
      .clk         (clk),
      .resetn      (resetn),
      .accept      (out_valid && out_ready),
      .stall_cycle (inflight_valid_q && !out_ready && !in_fault),
      .freeze      (in_fault),
      .fetch_cnt   (perf_fetch_cnt),
      .stall_cnt   (perf_stall_cnt)
   );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous big-endian ROM model
// and a scoreboard of expected (pc, instr) deliveries.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [31:0]  imem_addr;
   logic [31:0]  imem_rdata;
   logic [31:0]  out_instr;
   logic [31:0]  out_pc;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         redirect_valid = 1'b0;
   logic [31:0]  redirect_target = 32'd0;
   logic         fetch_fault;
   logic [31:0]  fault_addr;
   fetch_state_e state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]  perf_fetch_cnt;
   logic [31:0]  perf_stall_cnt;
`endif

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int n_acc   = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  rom_b [0:127];

   instr_fetch_unit #(.PC_RESET(32'h0), .IMEM_BYTES(128)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fetch_fault     (fetch_fault),
      .fault_addr      (fault_addr),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_stall_cnt  (perf_stall_cnt),
`endif
      .state           (state)
   );

   // Clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input int idx);
      if (idx == 0) return 32'h0000_0000;
      if (idx == 1) return 32'h00F0_0093;
      if (idx == 2) return 32'h03A0_C113;
      return 32'hA500_0000 | (32'(idx) << 8) | 32'(idx);
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) begin
         logic [31:0] w;
         w = rom_word(i);
         rom_b[4*i]   = w[31:24];
         rom_b[4*i+1] = w[23:16];
         rom_b[4*i+2] = w[15:8];
         rom_b[4*i+3] = w[7:0];
      end
   end

   // Synchronous ROM: registered big-endian read, zero during reset or out of range.
   always @(posedge clk) begin
      if (!resetn || imem_addr > 32'd124)
         imem_rdata <= 32'd0;
      else
         imem_rdata <= {rom_b[imem_addr[6:0]], rom_b[imem_addr[6:0] + 7'd1],
                        rom_b[imem_addr[6:0] + 7'd2], rom_b[imem_addr[6:0] + 7'd3]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back({pc, rom_word(int'(pc >> 2))});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted handshake must match the next expected pair.
   always @(negedge clk) begin
      if (resetn && out_valid && out_ready) begin
         n_acc++;
         if (exp_q.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL unexpected_out: observed pc 0x%08h expected no delivery", out_pc);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("out_pc", out_pc, e[63:32]);
            check("out_instr", out_instr, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      tick();
      tick();
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_fault", 32'(fetch_fault), 32'd0);
      check("rst_fault_addr", fault_addr, 32'd0);
      check("rst_state", 32'(state), 32'(BOOT));

      // Boot: pc 0, 4, 8 with a 3-cycle stall on pc 4.
      push_exp(32'd0);
      push_exp(32'd4);
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check("boot_cycle1_valid", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      check("boot_cycle2_valid", 32'(out_valid), 32'd1);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_pc", out_pc, 32'd4);
         check("stall_instr", out_instr, 32'h00F0_0093);
         check("stall_addr", imem_addr, 32'd4);
         tick();
      end
      out_ready = 1'b1;
      tick();
      // pc 8 presented while decode holds off, then redirected away.
      out_ready = 1'b0;
      @(negedge clk);
      check("after_stall_pc", out_pc, 32'd8);
      check("after_stall_valid", 32'(out_valid), 32'd1);
      check("after_stall_instr", out_instr, 32'h03A0_C113);
      check("accepts_so_far", 32'(n_acc), 32'd2);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, 32'd2);
      check("perf_stall", perf_stall_cnt, 32'd3);
`endif
      #1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h10;
      #1;
      check("redir_squash", 32'(out_valid), 32'd0);
      check("redir_addr", imem_addr, 32'h10);
      for (int pc = 16; pc <= 124; pc += 4) push_exp(32'(pc));
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      @(negedge clk);
      check("redir_target_pc", out_pc, 32'h10);
      check("redir_target_valid", 32'(out_valid), 32'd1);
      tick();
      @(negedge clk);
      check("redir_next_pc", out_pc, 32'h14);

      // Sequential run off the end of memory.
      for (int i = 0; i < 40; i++) begin
         if (fetch_fault) break;
         tick();
         @(negedge clk);
      end
      check("end_fault", 32'(fetch_fault), 32'd1);
      check("end_fault_addr", fault_addr, 32'd128);
      check("end_valid", 32'(out_valid), 32'd0);
      check("end_state", 32'(state), 32'(FAULT));
      check("end_addr", imem_addr, 32'd128);
      check("end_all_delivered", 32'(exp_q.size()), 32'd0);
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'd0;
      @(negedge clk);
      check("fault_redir_addr", imem_addr, 32'd128);
      check("fault_redir_valid", 32'(out_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("fault_redir_ignored", fault_addr, 32'd128);
      check("fault_redir_state", 32'(state), 32'(FAULT));

      // Reset, restart, then misaligned redirect.
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check("rst2_fault", 32'(fetch_fault), 32'd0);
      check("rst2_valid", 32'(out_valid), 32'd0);
      check("rst2_addr", imem_addr, 32'd0);
      push_exp(32'd0);
      tick();
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'h6;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("mis_fault", 32'(fetch_fault), 32'd1);
      check("mis_fault_addr", fault_addr, 32'h6);
      check("mis_valid", 32'(out_valid), 32'd0);

      // One-cycle reset clears the fault and restarts at PC_RESET.
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check("rst3_fault", 32'(fetch_fault), 32'd0);
      check("rst3_fault_addr", fault_addr, 32'd0);
      check("rst3_state", 32'(state), 32'(BOOT));
      push_exp(32'd0);
      push_exp(32'd4);
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      check("final_all_delivered", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
